// File: rtl/vt_pkg.sv
// Shared types and width defaults for the virtual time generator.
package vt_pkg;

  localparam int unsigned VT_TIME_W_DEF  = 32;
  localparam int unsigned VT_PRESC_W_DEF = 8;
  localparam int unsigned VT_STEP_W_DEF  = 16;
  localparam int unsigned VT_NUM_CMP_DEF = 2;

  typedef enum logic [1:0] {
    VT_IDLE = 2'd0,
    VT_RUN  = 2'd1,
    VT_STEP = 2'd2
  } vt_state_e;

endpackage

// File: rtl/vt_cmp_channel.sv
// One compare channel: one-cycle hit pulse plus a sticky flag where a
// coincident set beats a clear.
module vt_cmp_channel
  import vt_pkg::*;
#(
  parameter int unsigned TIME_SCALE_WIDTH = VT_TIME_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_i,
  input  logic [TIME_SCALE_WIDTH-1:0] time_nxt_i,
  input  logic [TIME_SCALE_WIDTH-1:0] cmp_val_i,
  input  logic                        cmp_en_i,
  input  logic                        cmp_clr_i,
  output logic                        hit_o,
  output logic                        flag_o
);

  logic hit_q, hit_d;
  logic flag_q, flag_d;

  // Compare against the value the counter is about to take.
  always_comb begin
    hit_d  = tick_i && cmp_en_i && (time_nxt_i == cmp_val_i);
    flag_d = flag_q;
    if (hit_d) begin
      flag_d = 1'b1;
    end else if (cmp_clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      flag_q <= flag_d;
    end
  end

  assign hit_o  = hit_q;
  assign flag_o = flag_q;

endmodule

// File: rtl/virtual_time_ctrl.sv
// Emulator virtual time base: run/pause, N-tick stepping, prescaler, load and
// compare channels. Define VT_SNAPSHOT_EN to add the snap_i/snap_o capture port.
module virtual_time_ctrl
  import vt_pkg::*;
#(
  parameter int unsigned TIME_SCALE_WIDTH = VT_TIME_W_DEF,
  parameter int unsigned PRESC_WIDTH      = VT_PRESC_W_DEF,
  parameter int unsigned STEP_WIDTH       = VT_STEP_W_DEF,
  parameter int unsigned NUM_CMP          = VT_NUM_CMP_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run_i,
  input  logic                                step_req_i,
  input  logic [STEP_WIDTH-1:0]               step_cnt_i,
  output logic                                step_busy_o,
  input  logic [PRESC_WIDTH-1:0]              presc_i,
  input  logic                                load_i,
  input  logic [TIME_SCALE_WIDTH-1:0]         load_val_i,
  input  logic [NUM_CMP*TIME_SCALE_WIDTH-1:0] cmp_val_i,
  input  logic [NUM_CMP-1:0]                  cmp_en_i,
  input  logic [NUM_CMP-1:0]                  cmp_clr_i,
  output logic [NUM_CMP-1:0]                  cmp_hit_o,
  output logic [NUM_CMP-1:0]                  cmp_flag_o,
  output logic [TIME_SCALE_WIDTH-1:0]         virtual_time_o,
  output logic                                tick_o,
  output logic                                wrap_o
`ifdef VT_SNAPSHOT_EN
  ,
  input  logic                                snap_i,
  output logic [TIME_SCALE_WIDTH-1:0]         snap_o
`endif
);

  vt_state_e                   state_q, state_d;
  logic [PRESC_WIDTH-1:0]      presc_cnt_q, presc_cnt_d;
  logic [STEP_WIDTH-1:0]       step_rem_q, step_rem_d;
  logic [TIME_SCALE_WIDTH-1:0] vt_q, vt_d;
  logic                        tick_q, tick_d;
  logic                        wrap_q, wrap_d;
  logic                        step_busy_q, step_busy_d;
  logic                        adv_c, fire_c, tick_c;

  // Prescaler and counter datapath; a load suppresses any tick this cycle.
  always_comb begin
    adv_c       = ((state_q == VT_RUN) && run_i) || (state_q == VT_STEP);
    fire_c      = adv_c && (presc_cnt_q >= presc_i);
    tick_c      = fire_c && !load_i;
    vt_d        = vt_q;
    presc_cnt_d = presc_cnt_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    if (load_i) begin
      vt_d        = load_val_i;
      presc_cnt_d = '0;
    end else if (fire_c) begin
      vt_d        = vt_q + TIME_SCALE_WIDTH'(1);
      presc_cnt_d = '0;
      tick_d      = 1'b1;
      wrap_d      = (vt_q == '1);
    end else if (adv_c) begin
      presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
    end
  end

  // Control FSM; run beats a simultaneous step request from IDLE.
  always_comb begin
    state_d    = state_q;
    step_rem_d = step_rem_q;
    unique case (state_q)
      VT_IDLE: begin
        if (run_i) begin
          state_d = VT_RUN;
        end else if (step_req_i && (step_cnt_i != '0)) begin
          state_d    = VT_STEP;
          step_rem_d = step_cnt_i;
        end
      end
      VT_RUN: begin
        if (!run_i) begin
          state_d = VT_IDLE;
        end
      end
      VT_STEP: begin
        if (tick_c) begin
          step_rem_d = step_rem_q - STEP_WIDTH'(1);
          if (step_rem_q == STEP_WIDTH'(1)) begin
            state_d = VT_IDLE;
          end
        end
      end
      default: state_d = VT_IDLE;
    endcase
    step_busy_d = (state_d == VT_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= VT_IDLE;
      presc_cnt_q <= '0;
      step_rem_q  <= '0;
      vt_q        <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      step_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      step_rem_q  <= step_rem_d;
      vt_q        <= vt_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      step_busy_q <= step_busy_d;
    end
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_cmp
    vt_cmp_channel #(
      .TIME_SCALE_WIDTH(TIME_SCALE_WIDTH)
    ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_c),
      .time_nxt_i(vt_d),
      .cmp_val_i (cmp_val_i[k*TIME_SCALE_WIDTH +: TIME_SCALE_WIDTH]),
      .cmp_en_i  (cmp_en_i[k]),
      .cmp_clr_i (cmp_clr_i[k]),
      .hit_o     (cmp_hit_o[k]),
      .flag_o    (cmp_flag_o[k])
    );
  end

`ifdef VT_SNAPSHOT_EN
  logic [TIME_SCALE_WIDTH-1:0] snap_q, snap_d;

  // Captures the pre-update time, so a coincident tick or load is not seen.
  always_comb begin
    snap_d = snap_q;
    if (snap_i) begin
      snap_d = vt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;
`endif

  assign virtual_time_o = vt_q;
  assign tick_o         = tick_q;
  assign wrap_o         = wrap_q;
  assign step_busy_o    = step_busy_q;

endmodule

// File: tb/tb_virtual_time_ctrl.sv
// Self-checking bench for virtual_time_ctrl: vector table through a scoreboard
// queue, plus hand-written reset and snapshot sequences.
module tb_virtual_time_ctrl;

  localparam int unsigned TW = 32;
  localparam int unsigned PW = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned NC = 2;

  logic             clk;
  logic             rst;
  logic             run_i;
  logic             step_req_i;
  logic [SW-1:0]    step_cnt_i;
  logic             step_busy_o;
  logic [PW-1:0]    presc_i;
  logic             load_i;
  logic [TW-1:0]    load_val_i;
  logic [NC*TW-1:0] cmp_val_i;
  logic [NC-1:0]    cmp_en_i;
  logic [NC-1:0]    cmp_clr_i;
  logic [NC-1:0]    cmp_hit_o;
  logic [NC-1:0]    cmp_flag_o;
  logic [TW-1:0]    virtual_time_o;
  logic             tick_o;
  logic             wrap_o;
`ifdef VT_SNAPSHOT_EN
  logic             snap_i;
  logic [TW-1:0]    snap_o;
`endif

  virtual_time_ctrl #(
    .TIME_SCALE_WIDTH(TW),
    .PRESC_WIDTH     (PW),
    .STEP_WIDTH      (SW),
    .NUM_CMP         (NC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run_i),
    .step_req_i    (step_req_i),
    .step_cnt_i    (step_cnt_i),
    .step_busy_o   (step_busy_o),
    .presc_i       (presc_i),
    .load_i        (load_i),
    .load_val_i    (load_val_i),
    .cmp_val_i     (cmp_val_i),
    .cmp_en_i      (cmp_en_i),
    .cmp_clr_i     (cmp_clr_i),
    .cmp_hit_o     (cmp_hit_o),
    .cmp_flag_o    (cmp_flag_o),
    .virtual_time_o(virtual_time_o),
    .tick_o        (tick_o),
    .wrap_o        (wrap_o)
`ifdef VT_SNAPSHOT_EN
    ,
    .snap_i        (snap_i),
    .snap_o        (snap_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          run;
    logic          sreq;
    logic [SW-1:0] scnt;
    logic [PW-1:0] presc;
    logic          load;
    logic [TW-1:0] lval;
    logic [NC-1:0] clr;
    logic [TW-1:0] e_vt;
    logic          e_tick;
    logic          e_wrap;
    logic          e_busy;
    logic [NC-1:0] e_hit;
    logic [NC-1:0] e_flag;
  } vec_t;

  typedef struct {
    int            row;
    logic [TW-1:0] vt;
    logic          tick;
    logic          wrap;
    logic          busy;
    logic [NC-1:0] hit;
    logic [NC-1:0] flag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(string name, int row, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endfunction

  function automatic void add(logic run, logic sreq, logic [SW-1:0] scnt, logic [PW-1:0] presc,
                              logic load, logic [TW-1:0] lval, logic [NC-1:0] clr,
                              logic [TW-1:0] e_vt, logic e_tick, logic e_wrap, logic e_busy,
                              logic [NC-1:0] e_hit, logic [NC-1:0] e_flag);
    vec_t v;
    v.run = run; v.sreq = sreq; v.scnt = scnt; v.presc = presc; v.load = load; v.lval = lval;
    v.clr = clr; v.e_vt = e_vt; v.e_tick = e_tick; v.e_wrap = e_wrap; v.e_busy = e_busy;
    v.e_hit = e_hit; v.e_flag = e_flag;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(string tag, int row, exp_t e);
    check({tag, ".vt"},   row, 64'(virtual_time_o), 64'(e.vt));
    check({tag, ".tick"}, row, 64'(tick_o),         64'(e.tick));
    check({tag, ".wrap"}, row, 64'(wrap_o),         64'(e.wrap));
    check({tag, ".busy"}, row, 64'(step_busy_o),    64'(e.busy));
    check({tag, ".hit"},  row, 64'(cmp_hit_o),      64'(e.hit));
    check({tag, ".flag"}, row, 64'(cmp_flag_o),     64'(e.flag));
  endtask

  function automatic exp_t mk_exp(int row, logic [TW-1:0] vt, logic tick, logic wrap, logic busy,
                                  logic [NC-1:0] hit, logic [NC-1:0] flag);
    exp_t e;
    e.row = row; e.vt = vt; e.tick = tick; e.wrap = wrap; e.busy = busy; e.hit = hit; e.flag = flag;
    return e;
  endfunction

  initial begin
    exp_t e;
    // Phase A: free run, presc 0; first cycle only leaves IDLE.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(1, 0, 0, 0, 0, 0, 0, TW'(i), 1, 0, 0, 0, 0);
    // Phase B: presc 3 for 16 cycles -> 4 evenly spaced ticks.
    for (int j = 0; j < 16; j++)
      add(1, 0, 0, 3, 0, 0, 0, TW'(10 + (j + 1) / 4), 1'((j % 4) == 3), 0, 0, 0, 0);
    // Phase C: pause two cycles into a period, resume keeps the partial count.
    add(1, 0, 0, 3, 0, 0, 0, 14, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 0, 0, 0, 14, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) add(0, 0, 0, 3, 0, 0, 0, 14, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 0, 0, 0, 14, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 0, 0, 0, 14, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 0, 0, 0, 15, 1, 0, 0, 0, 0);
    // Compare: channel 0 hits at 20 with coincident clear; channel 1 disabled.
    for (int i = 16; i <= 19; i++) add(1, 0, 0, 0, 0, 0, 0, TW'(i), 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2'b01, 20, 1, 0, 0, 2'b01, 2'b01);
    add(1, 0, 0, 0, 0, 0, 0, 21, 1, 0, 0, 2'b00, 2'b01);
    add(0, 0, 0, 0, 0, 0, 2'b01, 21, 0, 0, 0, 2'b00, 2'b00);
    // Phase D: step 5 with presc 1 -> 10 busy cycles; mid-burst request ignored.
    add(0, 1, 5, 1, 0, 0, 0, 21, 0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 1'(k == 2), 9, 1, 0, 0, 0, TW'(21 + (k + 1) / 2), 1'((k % 2) == 1), 0, 1'(k < 9), 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 26, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 26, 0, 0, 0, 0, 0);
    // Phase E: load near all-ones, wrap, then load coincident with a tick.
    add(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 32'h0000_0001, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 100, 0, 100, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 101, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 101, 0, 0, 0, 0, 0);

    rst        = 1'b1;
    run_i      = 1'b0;
    step_req_i = 1'b0;
    step_cnt_i = '0;
    presc_i    = '0;
    load_i     = 1'b0;
    load_val_i = '0;
    cmp_val_i  = {TW'(20), TW'(20)};
    cmp_en_i   = 2'b01;
    cmp_clr_i  = '0;
`ifdef VT_SNAPSHOT_EN
    snap_i     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", -1, mk_exp(-1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      run_i      = vecs[i].run;
      step_req_i = vecs[i].sreq;
      step_cnt_i = vecs[i].scnt;
      presc_i    = vecs[i].presc;
      load_i     = vecs[i].load;
      load_val_i = vecs[i].lval;
      cmp_clr_i  = vecs[i].clr;
      sb.push_back(mk_exp(i, vecs[i].e_vt, vecs[i].e_tick, vecs[i].e_wrap, vecs[i].e_busy,
                          vecs[i].e_hit, vecs[i].e_flag));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", i, 64'(0), 64'(1));
      end else begin
        e = sb.pop_front();
        check_outputs("vec", e.row, e);
      end
    end

    // Async reset mid-run clears outputs without waiting for a clock edge.
    @(negedge clk);
    run_i = 1'b1; step_req_i = 1'b0; load_i = 1'b0; cmp_clr_i = '0; presc_i = '0;
    repeat (4) @(posedge clk);
    #1;
    check("prereset.vt", 0, 64'(virtual_time_o), 64'(104));
    #2;
    rst = 1'b1;
    #1;
    check_outputs("midrst", 0, mk_exp(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    run_i = 1'b0;
    rst   = 1'b0;

`ifdef VT_SNAPSHOT_EN
    check("snap.reset", 0, 64'(snap_o), 64'(0));
    load_i = 1'b1; load_val_i = 7;
    @(negedge clk);
    load_i = 1'b0; run_i = 1'b1;
    @(posedge clk);
    #1;
    check("snap.pre_vt", 0, 64'(virtual_time_o), 64'(7));
    @(negedge clk);
    snap_i = 1'b1;
    @(posedge clk);
    #1;
    check("snap.val", 1, 64'(snap_o), 64'(7));
    check("snap.vt", 1, 64'(virtual_time_o), 64'(8));
    @(negedge clk);
    snap_i = 1'b0;
    @(posedge clk);
    #1;
    check("snap.hold", 2, 64'(snap_o), 64'(7));
    check("snap.vt", 2, 64'(virtual_time_o), 64'(9));
    @(negedge clk);
    run_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/virtual_time_ctrl.md
Name: virtual_time_ctrl

Overview:
- Parametrised virtual-time generator for the emulator. Extends the plain free-running cycle counter with:
  - run/pause control
  - N-tick single-step mode
  - programmable prescaler
  - synchronous load
  - NUM_CMP compare channels with hit pulses and sticky flags
- Sits at the emulator time base. Downstream models consume virtual_time_o and tick_o; the host controller drives the control inputs.

Parameters:
TIME_SCALE_WIDTH, 32, width of the virtual time counter
PRESC_WIDTH, 8, prescaler width; one tick every (presc_i+1) enabled cycles
STEP_WIDTH, 16, width of the single-step tick count
NUM_CMP, 2, number of compare channels (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
run_i  input  1  level; 1 = free-run
step_req_i  input  1  pulse; start step burst (honoured only in IDLE)
step_cnt_i  input  STEP_WIDTH  ticks to advance per step burst
step_busy_o  output  1  high while in STEP
presc_i  input  PRESC_WIDTH  prescale divisor minus one
load_i  input  1  pulse; load virtual time
load_val_i  input  TIME_SCALE_WIDTH  value to load
cmp_val_i  input  NUM_CMP*TIME_SCALE_WIDTH  compare values; channel k at slice k
cmp_en_i  input  NUM_CMP  per-channel compare enable
cmp_clr_i  input  NUM_CMP  per-channel sticky-flag clear
cmp_hit_o  output  NUM_CMP  one-cycle hit pulse
cmp_flag_o  output  NUM_CMP  sticky hit flag
virtual_time_o  output  TIME_SCALE_WIDTH  current virtual time
tick_o  output  1  high in the cycle virtual_time_o shows a newly advanced value
wrap_o  output  1  high in the cycle virtual_time_o shows 0 after an all-ones advance

Behaviour:
- Reset (async, rst=1): state=IDLE; presc_cnt=0; step_rem=0; all outputs 0.
- FSM states:
  - IDLE: IDLE->RUN if run_i. Else IDLE->STEP if step_req_i && step_cnt_i!=0, with step_rem<=step_cnt_i. If both, RUN wins. step_req_i with step_cnt_i==0 is ignored.
  - RUN: RUN->IDLE when run_i=0. Pause takes effect the same edge; no tick in that cycle. step_req_i is ignored.
  - STEP: run_i and step_req_i are ignored. Each tick decrements step_rem. The tick taking step_rem from 1 to 0 moves to IDLE. step_busy_o=(state==STEP).
- Advancing = state is RUN (with run_i=1) or STEP.
- Prescaler:
  - When advancing: presc_cnt>=presc_i -> tick, presc_cnt<=0; else presc_cnt++.
  - presc_cnt holds when not advancing.
  - presc_i=0 gives one tick per cycle. Lowering presc_i below presc_cnt ticks on the next advancing cycle.
- Tick: virtual_time <= virtual_time+1, modulo 2^TIME_SCALE_WIDTH. The all-ones to 0 transition asserts wrap_o in the same cycle as the 0 value appears.
- Outputs are registered. tick_o, wrap_o and cmp_hit_o align with the updated virtual_time_o (1-cycle latency from the advancing cycle).
- Load:
  - load_i has priority over a tick: virtual_time<=load_val_i, presc_cnt<=0.
  - No tick, wrap or compare hit in that cycle.
  - FSM state and step_rem are unaffected.
- Compare channel k:
  - On a tick whose new value equals cmp_val[k] and cmp_en_i[k]=1: cmp_hit_o[k]=1 for one cycle and cmp_flag_o[k] is set.
  - cmp_clr_i[k] clears the flag. If set and clear coincide, set wins.
  - Changing cmp_val or cmp_en mid-run affects only later ticks.
- Step burst of step_cnt with presc_i=P lasts exactly step_cnt*(P+1) cycles in STEP.

Optional Feature:
- VT_SNAPSHOT_EN, when defined:
  - Adds inputs snap_i (pulse) and output snap_o[TIME_SCALE_WIDTH].
  - On snap_i, snap_o registers the virtual_time_o value present in that cycle; it is visible the next cycle and held until the next snap.
  - If snap_i coincides with a load or tick, the pre-update value is captured.
  - snap_o resets to 0.
- When undefined: the ports are absent and no snapshot register exists.

Decomposition:
- Package vt_pkg holds:
  - vt_state_e enum {VT_IDLE, VT_RUN, VT_STEP}
  - localparam defaults for the widths
- Sub-module vt_cmp_channel (one compare, hit pulse, sticky flag with set-wins) is instantiated NUM_CMP times via generate.

Test Plan:
- Reset then run_i=1, presc_i=0 for 10 cycles -> virtual_time_o counts 1..10; tick_o high each cycle. rst=1 mid-run -> all outputs 0 immediately.
- presc_i=3, run 16 cycles -> exactly 4 ticks, spaced 4 cycles apart. Drop run_i after 2 cycles of a period, resume -> count continues without losing the partial period.
- IDLE, step_req_i with step_cnt_i=5, presc_i=1 -> step_busy_o high 10 cycles, time +5, return to IDLE. step_req_i with step_cnt_i=0 -> no change.
- load_val_i=32'hFFFF_FFFE, load_i, then run -> values FFFF_FFFF then 0 with wrap_o=1 on the 0 cycle. Load coincident with a would-be tick -> loaded value wins, tick_o=0.
- cmp_val[0]=20, cmp_en_i=2'b01, run from 0 -> cmp_hit_o[0] pulses with virtual_time_o=20 and flag stays set. cmp_clr_i[0] in the hit cycle -> flag remains set. cmp_en_i[1]=0 at matching value -> no hit on channel 1.
- VT_SNAPSHOT_EN defined: snap_i while virtual_time_o=7 with a coincident tick -> snap_o=7 next cycle, virtual_time_o=8.
